// File: rtl/shift_pkg.sv
// Shared definitions for the multi-cycle shift sequencer.
//   - Operation encodings carried on in_op.
//   - Controller state enumeration.
package shift_pkg;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/shift_stage.sv
// Single reusable logarithmic shift layer (combinational).
// Ports:
//   data    in   DATA_W   value entering this layer
//   k       in   SHAMT_W  layer index; the shift distance is 2^k
//   en      in   1        shift when set, pass through when clear
//   op      in   2        SLL / SRL / SRA / reserved (pass through)
//   fill    in   1        sign bit shifted in for SRA
//   result  out  DATA_W   layer output
module shift_stage
  import shift_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int SHAMT_W = $clog2(DATA_W)
) (
  input  logic [DATA_W-1:0]  data,
  input  logic [SHAMT_W-1:0] k,
  input  logic               en,
  input  logic [1:0]         op,
  input  logic               fill,
  output logic [DATA_W-1:0]  result
);

  logic [SHAMT_W-1:0]      amt;
  logic signed [DATA_W:0]  ext;
  logic signed [DATA_W:0]  sra;

  always_comb begin
    amt    = SHAMT_W'(1) << k;
    // Prepend the fill bit so the arithmetic shift replicates it rather
    // than whatever currently sits in the top data bit.
    ext    = {fill, data};
    sra    = ext >>> amt;
    result = data;
    if (en) begin
      case (op)
        OP_SLL:  result = data << amt;
        OP_SRL:  result = data >> amt;
        OP_SRA:  result = sra[DATA_W-1:0];
        default: result = data;
      endcase
    end
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: accepts one SLL/SRL/SRA request over a
// valid/ready handshake, resolves it one shift-amount bit per clock through
// a single shift_stage, and holds the result until the consumer takes it.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   in_valid/in_ready   request handshake (in_ready high only in IDLE)
//   in_a, in_shamt      operand and shift amount (sampled on accept)
//   in_op               00 SLL, 01 SRL, 10 SRA, 11 pass through
//   out_valid/out_ready result handshake (out_valid high only in DONE)
//   out_result          data register
//   busy                high while SHIFT or DONE
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W-1:0]           in_a,
  input  logic [$clog2(DATA_W)-1:0]   in_shamt,
  input  logic [1:0]                  in_op,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_result,
  output logic                        busy
);

  localparam int SHAMT_W = $clog2(DATA_W);
  localparam logic [SHAMT_W-1:0] K_LAST = SHAMT_W'(SHAMT_W - 1);

  state_t              state;
  logic [SHAMT_W-1:0]  k;
  logic [DATA_W-1:0]   data;
  logic [SHAMT_W-1:0]  shamt;
  logic [1:0]          op;
  logic                fill;
  logic [DATA_W-1:0]   stage_out;

  shift_stage #(
    .DATA_W  (DATA_W),
    .SHAMT_W (SHAMT_W)
  ) u_stage (
    .data   (data),
    .k      (k),
    .en     (shamt[k]),
    .op     (op),
    .fill   (fill),
    .result (stage_out)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      k     <= '0;
      data  <= '0;
      shamt <= '0;
      op    <= OP_SLL;
      fill  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (in_valid) begin
            data  <= in_a;
            shamt <= in_shamt;
            op    <= in_op;
            fill  <= in_a[DATA_W-1];
            k     <= '0;
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          // Every layer is applied, even for zero bits, so latency is fixed.
          data <= stage_out;
          if (k == K_LAST) begin
            k     <= '0;
            state <= ST_DONE;
          end else begin
            k <= k + SHAMT_W'(1);
          end
        end
        ST_DONE: begin
          if (out_ready) state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Outputs decode registered state only; nothing flows from in_* to out_*.
  assign in_ready   = (state == ST_IDLE);
  assign out_valid  = (state == ST_DONE);
  assign busy       = (state != ST_IDLE);
  assign out_result = data;

endmodule

// File: tb/tb_shift_seq_ctrl.sv
module tb_shift_seq_ctrl;

  localparam int DATA_W = 32;
  localparam int SHAMT_W = 5;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_a;
  logic [4:0]        in_shamt;
  logic [1:0]        in_op;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_result;
  logic              busy;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] sb[$];

  shift_seq_ctrl #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_a       (in_a),
    .in_shamt   (in_shamt),
    .in_op      (in_op),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model(input logic [31:0] a, input logic [4:0] s,
                                        input logic [1:0] op);
    case (op)
      2'b00:   return a << s;
      2'b01:   return a >> s;
      2'b10:   return $signed(a) >>> s;
      default: return a;
    endcase
  endfunction

  // Drive one request; returns after the accept edge (+1 time unit).
  task automatic issue(input logic [31:0] a, input logic [4:0] s, input logic [1:0] op);
    int guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b1; in_a = a; in_shamt = s; in_op = op;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Count edges from accept until out_valid; -1 on timeout.
  task automatic wait_done(output int lat);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    // Reset together with a request: reset wins, nothing captured.
    rst = 1'b1; in_valid = 1'b1; in_a = 32'hFFFF_FFFF; in_shamt = 5'd1; in_op = 2'b00;
    @(posedge clk); #1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_result !== 32'h0) begin
      n_fail++;
      $display("FAIL reset_values: in_ready=%b out_valid=%b busy=%b out_result=%h, required 1 0 0 00000000",
               in_ready, out_valid, busy, out_result);
    end
  endtask

  task automatic test_long_sll();
    logic [31:0] exp;
    int lat = -1;
    int rdy_bad = 0;
    sb.push_back(32'h8000_0000);
    issue(32'h0000_0001, 5'd31, 2'b00);
    for (int c = 1; c <= 40; c++) begin
      if (in_ready !== 1'b0) rdy_bad++;
      @(posedge clk); #1;
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    exp = sb.pop_front();
    n_checks++;
    if (lat != 5) begin
      n_fail++;
      $display("FAIL long_sll_latency: got %0d cycles, required 5", lat);
    end
    n_checks++;
    if (rdy_bad != 0) begin
      n_fail++;
      $display("FAIL long_sll_in_ready: in_ready high on %0d busy cycles, required 0", rdy_bad);
    end
    n_checks++;
    if (out_result !== exp) begin
      n_fail++;
      $display("FAIL long_sll_result: got %h, required %h", out_result, exp);
    end
    consume();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL long_sll_return_idle: in_ready=%b out_valid=%b, required 1 0", in_ready, out_valid);
    end
  endtask

  task automatic test_sra_srl();
    logic [31:0] av [3] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFF0};
    logic [1:0]  ov [3] = '{2'b10, 2'b01, 2'b10};
    logic [31:0] ev [3] = '{32'hF800_0000, 32'h0800_0000, 32'h07FF_FFFF};
    logic [31:0] exp;
    int lat;
    for (int i = 0; i < 3; i++) begin
      sb.push_back(ev[i]);
      issue(av[i], 5'd4, ov[i]);
      wait_done(lat);
      exp = sb.pop_front();
      n_checks++;
      if (lat != 5 || out_result !== exp) begin
        n_fail++;
        $display("FAIL sra_srl_%0d: result %h latency %0d, required %h latency 5", i, out_result, lat, exp);
      end
      consume();
    end
  endtask

  task automatic test_zero_rsv();
    logic [1:0] ov [5] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b11};
    logic [4:0] sv [5] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd7};
    logic [31:0] exp;
    int lat;
    for (int i = 0; i < 5; i++) begin
      sb.push_back(32'hDEAD_BEEF);
      issue(32'hDEAD_BEEF, sv[i], ov[i]);
      wait_done(lat);
      exp = sb.pop_front();
      n_checks++;
      if (lat != 5 || out_result !== exp) begin
        n_fail++;
        $display("FAIL zero_rsv_%0d: result %h latency %0d, required %h latency 5", i, out_result, lat, exp);
      end
      consume();
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp;
    int lat;
    int bad = 0;
    sb.push_back(32'h0000_FF00);
    issue(32'h0000_00FF, 5'd8, 2'b00);
    wait_done(lat);
    exp = sb.pop_front();
    in_valid = 1'b1; in_a = 32'h1234_5678; in_shamt = 5'd3; in_op = 2'b00;
    for (int c = 0; c < 10; c++) begin
      if (out_valid !== 1'b1 || out_result !== exp || in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    n_checks++;
    if (lat != 5 || bad != 0 || out_result !== exp) begin
      n_fail++;
      $display("FAIL backpressure_hold: unstable cycles %0d latency %0d result %h, required 0 5 %h",
               bad, lat, out_result, exp);
    end
    consume();
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_result !== exp) begin
      n_fail++;
      $display("FAIL backpressure_release: in_ready=%b out_valid=%b busy=%b result=%h, required 1 0 0 %h",
               in_ready, out_valid, busy, out_result, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] exp;
    int lat;
    issue(32'hFFFF_FFFF, 5'd3, 2'b00);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b0;
    n_checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || out_result !== 32'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b result=%h, required 1 0 0 00000000",
               in_ready, out_valid, busy, out_result);
    end
    sb.push_back(32'h0000_0006);
    issue(32'h0000_0003, 5'd1, 2'b00);
    wait_done(lat);
    exp = sb.pop_front();
    n_checks++;
    if (lat != 5 || out_result !== exp) begin
      n_fail++;
      $display("FAIL reset_mid_after: result %h latency %0d, required %h latency 5", out_result, lat, exp);
    end
    consume();
  endtask

  task automatic test_random();
    logic [31:0] a, exp, held;
    logic [4:0]  s;
    logic [1:0]  op;
    int lat, stall, bad;
    for (int i = 0; i < 1000; i++) begin
      a  = $urandom;
      s  = 5'($urandom_range(0, 31));
      op = 2'($urandom_range(0, 3));
      sb.push_back(model(a, s, op));
      issue(a, s, op);
      wait_done(lat);
      held = out_result;
      stall = $urandom_range(0, 3);
      bad = 0;
      for (int c = 0; c < stall; c++) begin
        @(posedge clk); #1;
        if (out_valid !== 1'b1 || out_result !== held) bad++;
      end
      exp = sb.pop_front();
      n_checks++;
      if (lat != 5 || bad != 0 || out_result !== exp) begin
        n_fail++;
        $display("FAIL random_%0d: a=%h s=%0d op=%0d result %h latency %0d unstable %0d, required %h latency 5",
                 i, a, s, op, out_result, lat, bad, exp);
      end
      consume();
    end
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_a = '0; in_shamt = '0; in_op = '0; out_ready = 1'b0;
    test_reset();
    test_long_sll();
    test_sra_srl();
    test_zero_rsv();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/shift_seq_ctrl.md
# shift_seq_ctrl

Multi-cycle shift sequencer for the execute stage. It accepts one SLL/SRL/SRA request through a valid/ready handshake and resolves it as a logarithmic shift, one shift-amount bit per clock. A single shift layer is reused over successive cycles instead of five parallel mux layers. The result is held until the consumer accepts it.

## Interface
- DATA_W, 32: operand width; must be a power of two, at least 2.
- SHAMT_W, $clog2(DATA_W): shift-amount width; equals the number of stages. Derived; not overridden.

- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  block can accept a request.
- in_a  in  DATA_W  operand.
- in_shamt  in  SHAMT_W  shift amount.
- in_op  in  2  00 SLL, 01 SRL, 10 SRA, 11 reserved.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_result  out  DATA_W  shifted value.
- busy  out  1  high in SHIFT or DONE.

## Operation
- **States:**
  - IDLE: in_ready=1.
  - SHIFT: stage counter k runs 0..SHAMT_W-1.
  - DONE: out_valid=1.
- **Accept:** in_valid & in_ready on an edge captures in_a into the data register, and captures in_shamt and in_op. Sets k=0, state→SHIFT.
- **SHIFT, each cycle:** the data register is replaced by the stage-k output of shift_stage. If shamt[k]=1, the data shifts by 2^k, otherwise it passes through. k increments. When k=SHAMT_W-1 the update happens and state→DONE.
- **Fill:** SLL fills with 0. SRL fills with 0. SRA fills with the captured operand's bit DATA_W-1, taken from the original in_a, not from the current data.
- **Reserved op:** op=11 passes data unchanged every stage. The result equals in_a, with the same latency.
- **DONE:** out_result = data register. out_valid stays 1 and out_result stays stable until out_ready=1. On that edge state→IDLE and out_valid→0.
- **Handshake rules:** in_ready=0 in SHIFT and DONE; in_valid there is ignored, with no capture. in_op, in_shamt and in_a are sampled only on the accept edge.
- **Fixed latency:** there is no early exit for zero bits. shamt=0 takes the full latency.
- **Reset:** rst takes priority over every event, including an accept or out_ready in the same cycle. rst mid-SHIFT or in DONE discards the operation.
- **Reset values:** state=IDLE, k=0, data=0, in_ready=1, out_valid=0, out_result=0, busy=0.

## Timing
- Accept edge E0. Stage updates occur on E1..E_SHAMT_W.
- out_valid is high after edge E_SHAMT_W. For DATA_W=32 that is 5 cycles after accept.
- Minimum occupancy is SHAMT_W+1 cycles, with out_ready tied high. in_ready returns the cycle after the DONE handshake.
- No back-to-back accept in the DONE→IDLE cycle. Peak throughput is 1 op per SHAMT_W+2 cycles.
- All outputs are registered or decoded from registered state. There are no combinational paths from in_* to out_*.
- in_ready depends only on state. It does not depend on out_ready.

## Structure
- **Package shift_pkg:**
  - op encodings: OP_SLL=2'b00, OP_SRL=2'b01, OP_SRA=2'b10, OP_RSV=2'b11.
  - state enum: ST_IDLE, ST_SHIFT, ST_DONE.
- **Sub-module shift_stage:** combinational.
  - Inputs: data[DATA_W], stage index k, enable bit, op, fill bit.
  - Output: data shifted by 2^k in the op direction when enabled, else passthrough.
  - Instantiated once. The controller owns the counter, FSM and registers.

## Test plan
- **Long SLL:** SLL, a=0x00000001, shamt=31 → out_result=0x80000000. out_valid rises exactly 5 cycles after the accept edge; in_ready=0 meanwhile.
- **SRA vs SRL:** SRA, a=0x80000000, shamt=4 → 0xF8000000. Then SRL with the same operands → 0x08000000. Then SRA, a=0x7FFFFFF0, shamt=4 → 0x07FFFFFF.
- **Zero shift and reserved op:** a=0xDEADBEEF, shamt=0 with op=SLL, SRL, SRA and 11 → all give 0xDEADBEEF with the full 5-cycle latency. Also op=11, shamt=7 → 0xDEADBEEF.
- **Backpressure:** out_ready=0 for 10 cycles in DONE → out_valid and out_result stable. in_ready stays 0, and a concurrent in_valid with a=0x12345678 is not captured. Releasing out_ready → IDLE next cycle.
- **Reset mid-operation:** assert rst on the 3rd SHIFT cycle → next cycle IDLE, in_ready=1, out_valid=0, out_result=0. A following SLL, a=0x3, shamt=1 → 0x6.
- **Random sweep:** 1000 random (a, shamt, op) with random out_ready stalls → matches the reference model (a<<s, a>>s, $signed(a)>>>s).
